sdram_pattern_tester: RTL

Parametrised successor to the fixed ROM-fed SDRAM test top. It generates a selectable data pattern, pushes N words into the SDRAM controller write FIFO, and waits for the FIFO to drain. It then reloads the read side, pulls N words back, and compares each word against a regenerated copy of the pattern. It sits between sdram_control_top's FIFO ports and the status/seven-segment display logic.

---
 rtl/sdram_pattern_tester_if.sv | 44 ++++
 rtl/sdram_pattern_tester.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sdram_pattern_tester_if.sv
// Bus between the pattern tester and its surroundings: test control/status plus
// the write/read FIFO ports of the SDRAM controller.
interface sdram_pattern_tester_if #(
  parameter int DSIZE = 16,
  parameter int LEN_W = 24
) ();

  logic             start;
  logic [1:0]       mode;
  logic [DSIZE-1:0] seed;
  logic [LEN_W-1:0] num_words;

  logic [DSIZE-1:0] wr_data;
  logic             wr_en;
  logic             wr_full;
  logic [LEN_W-1:0] wr_use;

  logic             rd_load;
  logic             rd_en;
  logic [DSIZE-1:0] rd_data;
  logic             rd_empty;

  logic             busy;
  logic             done;
  logic             pass;
  logic [LEN_W-1:0] err_cnt;
  logic [LEN_W-1:0] first_err_addr;
  logic [DSIZE-1:0] first_err_data;

  modport master (
    input  start, mode, seed, num_words,
    input  wr_full, wr_use, rd_data, rd_empty,
    output wr_data, wr_en, rd_load, rd_en,
    output busy, done, pass, err_cnt, first_err_addr, first_err_data
  );

  modport slave (
    output start, mode, seed, num_words,
    output wr_full, wr_use, rd_data, rd_empty,
    input  wr_data, wr_en, rd_load, rd_en,
    input  busy, done, pass, err_cnt, first_err_addr, first_err_data
  );

endinterface

// File: rtl/sdram_pattern_tester.sv
// Writes N pattern words into the SDRAM controller FIFO, reloads the read side,
// reads them back and compares against an independently regenerated pattern.
module sdram_pattern_tester #(
  parameter int               DSIZE         = 16,
  parameter int               LEN_W         = 24,
  parameter int               SETTLE_CYCLES = 64,
  parameter logic [DSIZE-1:0] LFSR_TAPS     = DSIZE'(16'hB400)
) (
  input logic                    Clk,
  input logic                    Rst,
  sdram_pattern_tester_if.master bus
);

  localparam int               SW          = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [LEN_W-1:0] LEN_ONE     = LEN_W'(1);
  localparam logic [DSIZE-1:0] D_ONE       = DSIZE'(1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    DRAIN,
    SETTLE,
    RELOAD,
    READ,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] wrCnt_q, wrCnt_d;
  logic [LEN_W-1:0] rdIssue_q, rdIssue_d;
  logic [LEN_W-1:0] cmpDone_q, cmpDone_d;
  logic [LEN_W-1:0] cmpIdx_q, cmpIdx_d;
  logic [LEN_W-1:0] errCnt_q, errCnt_d;
  logic [LEN_W-1:0] firstAddr_q, firstAddr_d;
  logic [DSIZE-1:0] wrGen_q, wrGen_d;
  logic [DSIZE-1:0] rdGen_q, rdGen_d;
  logic [DSIZE-1:0] cmpExp_q, cmpExp_d;
  logic [DSIZE-1:0] firstData_q, firstData_d;
  logic             cmpValid_q, cmpValid_d;
  logic [SW-1:0]    settle_q, settle_d;

  logic startAcc;
  logic wrFire;
  logic rdFire;
  logic wrLast;
  logic cmpLast;
  logic settleLast;
  logic mismatch;

  // Generator state is the LFSR value in mode 1, the rotating one-hot in mode 2,
  // and the running seed+i counter otherwise.
  function automatic logic [DSIZE-1:0] genInit(input logic [1:0] m, input logic [DSIZE-1:0] s);
    logic [31:0] pos;
    pos     = 32'(s) % DSIZE;
    genInit = s;
    case (m)
      2'd1:    if (s == '0) genInit = D_ONE;
      2'd2:    genInit = D_ONE << pos;
      default: genInit = s;
    endcase
  endfunction

  function automatic logic [DSIZE-1:0] genNext(input logic [1:0] m, input logic [DSIZE-1:0] g);
    case (m)
      2'd1:    genNext = (g >> 1) ^ (g[0] ? LFSR_TAPS : '0);
      2'd2:    genNext = {g[DSIZE-2:0], g[DSIZE-1]};
      default: genNext = g + D_ONE;
    endcase
  endfunction

  function automatic logic [DSIZE-1:0] genOut(input logic [1:0] m, input logic [DSIZE-1:0] g);
    genOut = (m == 2'd3) ? ~g : g;
  endfunction

  assign startAcc   = ((state_q == IDLE) || (state_q == DONE)) && bus.start;
  assign wrLast     = wrFire && (wrCnt_q == (len_q - LEN_ONE));
  assign cmpLast    = cmpValid_q && (cmpDone_q == (len_q - LEN_ONE));
  assign settleLast = (settle_q == SETTLE_LAST);
  assign mismatch   = cmpValid_q && (bus.rd_data != cmpExp_q);

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (startAcc) state_d = WRITE;
      WRITE:   if (wrLast) state_d = DRAIN;
      DRAIN:   if (bus.wr_use == '0) state_d = SETTLE;
      SETTLE:  if (settleLast) state_d = RELOAD;
      RELOAD:  state_d = READ;
      READ:    if (cmpLast) state_d = DONE;
      DONE:    if (startAcc) state_d = WRITE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wrFire = 1'b0;
    rdFire = 1'b0;
    if (state_q == WRITE) wrFire = !bus.wr_full && (wrCnt_q < len_q);
    if (state_q == READ)  rdFire = !bus.rd_empty && (rdIssue_q < len_q);
    bus.wr_en          = wrFire;
    bus.rd_en          = rdFire;
    bus.rd_load        = (state_q == RELOAD);
    bus.busy           = (state_q != IDLE) && (state_q != DONE);
    bus.done           = (state_q == DONE);
    bus.pass           = (state_q == DONE) && (errCnt_q == '0);
    bus.wr_data        = genOut(mode_q, wrGen_q);
    bus.err_cnt        = errCnt_q;
    bus.first_err_addr = firstAddr_q;
    bus.first_err_data = firstData_q;
  end

  // Compare pipeline: an rd_en captures the expected word; the comparison runs
  // the next cycle when the controller presents rd_data.
  always_comb begin
    mode_d      = mode_q;
    len_d       = len_q;
    wrCnt_d     = wrCnt_q;
    rdIssue_d   = rdIssue_q;
    cmpDone_d   = cmpDone_q;
    cmpIdx_d    = cmpIdx_q;
    errCnt_d    = errCnt_q;
    firstAddr_d = firstAddr_q;
    firstData_d = firstData_q;
    wrGen_d     = wrGen_q;
    rdGen_d     = rdGen_q;
    cmpExp_d    = cmpExp_q;
    cmpValid_d  = 1'b0;
    settle_d    = settle_q;

    if (startAcc) begin
      mode_d      = bus.mode;
      len_d       = (bus.num_words == '0) ? LEN_ONE : bus.num_words;
      wrCnt_d     = '0;
      rdIssue_d   = '0;
      cmpDone_d   = '0;
      cmpIdx_d    = '0;
      errCnt_d    = '0;
      firstAddr_d = '0;
      firstData_d = '0;
      wrGen_d     = genInit(bus.mode, bus.seed);
      rdGen_d     = genInit(bus.mode, bus.seed);
      cmpExp_d    = '0;
      settle_d    = '0;
    end else begin
      if (wrFire) begin
        wrGen_d = genNext(mode_q, wrGen_q);
        wrCnt_d = wrCnt_q + LEN_ONE;
      end
      if (state_q == SETTLE) settle_d = settleLast ? '0 : settle_q + SW'(1);
      if (rdFire) begin
        cmpValid_d = 1'b1;
        cmpExp_d   = genOut(mode_q, rdGen_q);
        cmpIdx_d   = rdIssue_q;
        rdGen_d    = genNext(mode_q, rdGen_q);
        rdIssue_d  = rdIssue_q + LEN_ONE;
      end
      if (cmpValid_q) begin
        cmpDone_d = cmpDone_q + LEN_ONE;
        if (mismatch) begin
          if (errCnt_q != '1) errCnt_d = errCnt_q + LEN_ONE;
          if (errCnt_q == '0) begin
            firstAddr_d = cmpIdx_q;
            firstData_d = bus.rd_data;
          end
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      mode_q      <= '0;
      len_q       <= '0;
      wrCnt_q     <= '0;
      rdIssue_q   <= '0;
      cmpDone_q   <= '0;
      cmpIdx_q    <= '0;
      errCnt_q    <= '0;
      firstAddr_q <= '0;
      firstData_q <= '0;
      wrGen_q     <= '0;
      rdGen_q     <= '0;
      cmpExp_q    <= '0;
      cmpValid_q  <= 1'b0;
      settle_q    <= '0;
    end else begin
      mode_q      <= mode_d;
      len_q       <= len_d;
      wrCnt_q     <= wrCnt_d;
      rdIssue_q   <= rdIssue_d;
      cmpDone_q   <= cmpDone_d;
      cmpIdx_q    <= cmpIdx_d;
      errCnt_q    <= errCnt_d;
      firstAddr_q <= firstAddr_d;
      firstData_q <= firstData_d;
      wrGen_q     <= wrGen_d;
      rdGen_q     <= rdGen_d;
      cmpExp_q    <= cmpExp_d;
      cmpValid_q  <= cmpValid_d;
      settle_q    <= settle_d;
    end
  end

endmodule
